// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared phase, opcode and sequencer-state encodings
package cpu_pkg;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        DATA_SETUP = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP_WAIT = 3'd2,
        HALTED    = 3'd3,
        ERROR     = 3'd4
    } seq_state_e;

    // Halt is only honoured here; the controller never touches memory in this phase.
    localparam phase_e HALT_PHASE   = OP_ADDR;
    localparam phase_e RESUME_PHASE = OP_FETCH;

    function automatic phase_e next_phase(input phase_e p);
        return phase_e'(p + 3'd1);
    endfunction

endpackage

// File: rtl/stall_timer.sv
// rtl/stall_timer.sv - memory-wait stall counter with timeout compare
module stall_timer #(
    parameter int STALL_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(STALL_MAX - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    // Fires during the STALL_MAX-th consecutive stall cycle.
    assign expired = tick && (count == LAST);

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - eight-phase instruction sequencer with stall timeout
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int STALL_MAX = 15,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             halt,
    input  logic             rd,
    input  logic             wr,
    input  logic             mem_ready,
    output logic [2:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    seq_state_e state;
    phase_e     phase_q;
    logic       stall;
    logic       halt_hit;
    logic       expired;

    // Stall takes priority over halt; phase 4 never needs memory anyway.
    assign stall    = (state == RUN) && (rd || wr) && !mem_ready;
    assign halt_hit = (state == RUN) && !stall && halt && (phase_q == HALT_PHASE);

    stall_timer #(
        .STALL_MAX(STALL_MAX)
    ) u_stall_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!stall),
        .tick   (stall),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_q   <= INST_ADDR;
            running   <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
            instr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                        phase_q <= INST_ADDR;
                    end
                end
                RUN: begin
                    if (stall) begin
                        if (expired) begin
                            state   <= ERROR;
                            running <= 1'b0;
                            err     <= 1'b1;
                        end
                    end else if (halt_hit) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else begin
                        phase_q <= next_phase(phase_q);
                        if (phase_q == STORE) begin
                            if (~&instr_cnt) begin
                                instr_cnt <= instr_cnt + CNT_W'(1);
                            end
                            if (step_mode) begin
                                state   <= STEP_WAIT;
                                running <= 1'b0;
                            end
                        end
                    end
                end
                STEP_WAIT: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                HALTED: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                        halted  <= 1'b0;
                        phase_q <= RESUME_PHASE;
                    end
                end
                ERROR: begin
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    halted  <= 1'b0;
                    phase_q <= INST_ADDR;
                end
            endcase
        end
    end

    assign phase = phase_q;

endmodule
